// File: rtl/apb_spi_master_core_if.sv
// APB slave-side bus bundle for apb_spi_master_core.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : driven by the APB master
//   PRDATA/PREADY                    : returned by the SPI core
interface apb_spi_master_core_if #(
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic              PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_spi_master_core.sv
// APB-fed SPI mode-0 master: TX register write (PADDR=1) launches a transfer,
// RX register (PADDR=0) holds the last received byte.
// Ports:
//   PCLK, PRESET      : clock, synchronous active-high reset
//   apb (slave)       : PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY out
//   SCLK, MOSI, SS_n  : SPI outputs (SCLK idles low, SS_n active low)
//   MISO              : SPI data in, assumed synchronous to PCLK
//   BUSY, DONE        : transfer in progress, one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for a TX write
// LOW    | SCLK low half-period, MOSI holds current bit
// HIGH   | SCLK high half-period, MISO already sampled
// FINISH | one-cycle gap with SS_n high; may accept the next write
module apb_spi_master_core #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_spi_master_core_if.slave   apb,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic                   SS_n,
    output logic                   BUSY,
    output logic                   DONE
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_reg_q, rx_reg_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                ss_n_q, ss_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                div_last;
    logic                bit_last;
    logic [DATA_W-1:0]   tx_next;

    assign accept   = apb.PSEL & apb.PENABLE & apb.PWRITE & apb.PADDR & ~busy_q;
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign tx_next  = tx_shift_q << 1;

    // Only TX writes stall; reads and RX-address writes always complete.
    assign apb.PREADY = ~(apb.PSEL & apb.PWRITE & apb.PADDR & busy_q);
    assign apb.PRDATA = (apb.PSEL & ~apb.PWRITE & ~apb.PADDR) ? rx_reg_q : '0;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_reg_d   = rx_reg_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                // FINISH also accepts, so a stalled write starts right after
                // the single SS_n-high gap cycle.
                state_d = IDLE;
                if (accept) begin
                    state_d    = LOW;
                    tx_shift_d = apb.PWDATA;
                    mosi_d     = apb.PWDATA[DATA_W-1];
                    ss_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    div_d      = '0;
                end
            end
            LOW: begin
                if (div_last) begin
                    div_d      = '0;
                    state_d    = HIGH;
                    sclk_d     = 1'b1;
                    rx_shift_d = (rx_shift_q << 1) | DATA_W'(MISO);
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_last) begin
                        state_d  = FINISH;
                        ss_n_d   = 1'b1;
                        mosi_d   = 1'b0;
                        busy_d   = 1'b0;
                        rx_reg_d = rx_shift_q;
                        done_d   = 1'b1;
                    end else begin
                        state_d    = LOW;
                        tx_shift_d = tx_next;
                        mosi_d     = tx_next[DATA_W-1];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_reg_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_reg_q   <= rx_reg_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign SS_n = ss_n_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
endmodule

// File: doc/apb_spi_master_core.md
Name: apb_spi_master_core

Overview:
- Register and shift engine that sits directly downstream of the APB register-select decode in the APB-SPI bridge.
- An APB write to the SPI input register (PADDR=1) loads a TX byte and launches one SPI mode-0 transfer.
- The received byte is latched into the SPI output register, which APB reads at PADDR=0.
- Provides APB wait-state handshaking, an SCLK divider and the transfer state machine.

Parameters:
- DATA_W, 8: transfer width in bits; also the width of the TX/RX registers and PWDATA/PRDATA.
- CLK_DIV, 4: PCLK cycles per SCLK half-period; legal range 1..255.

Ports:
- PCLK  input  1  system/APB clock; all logic rising-edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  1  1 = SPI input (TX) register, 0 = SPI output (RX) register.
- PWDATA  input  DATA_W  write data.
- PRDATA  output  DATA_W  read data.
- PREADY  output  1  APB ready; low inserts wait states.
- SCLK  output  1  SPI clock, idles low.
- MOSI  output  1  SPI data out, MSB first.
- MISO  input  1  SPI data in.
- SS_n  output  1  slave select, active low.
- BUSY  output  1  high while a transfer is in progress.
- DONE  output  1  one-PCLK pulse when a transfer completes.

Behaviour:
- Clock and reset: one clock (PCLK); reset is synchronous and active-high (PRESET).
- Reset values: PRDATA=0, rx_reg=0, tx_shift=0, SCLK=0, MOSI=0, SS_n=1, BUSY=0, DONE=0, state=IDLE, divider and bit counters=0.
- Reset mid-transfer: the transfer is aborted on the next edge, all outputs return to their reset values, and no DONE pulse is generated.
- PREADY (combinational):
  - PREADY = !(PSEL & PWRITE & PADDR & BUSY).
  - Reads are never stalled. Writes to TX are stalled while BUSY.
- Write accept: PSEL & PENABLE & PWRITE & PADDR & !BUSY at a rising edge T.
- Writes with PADDR=0 complete with PREADY=1 and have no effect.
- PRDATA:
  - Equals rx_reg whenever PSEL & !PWRITE & !PADDR; otherwise 0.
  - Reads with PADDR=1 return 0.
- States: IDLE, LOW (SCLK=0 half-period), HIGH (SCLK=1 half-period), FINISH.
- IDLE → LOW on write accept at edge T. At T+1:
  - tx_shift=PWDATA, MOSI=PWDATA[DATA_W-1]
  - SS_n=0, BUSY=1, bit counter=0, divider=0
- Divider: counts 0..CLK_DIV-1 in LOW and HIGH; the state toggles when divider reaches CLK_DIV-1.
- LOW → HIGH:
  - SCLK rises.
  - MISO is sampled into rx_shift LSB (rx_shift shifts left).
- HIGH → LOW, if bit counter < DATA_W-1:
  - SCLK falls.
  - tx_shift shifts left and MOSI presents the next bit.
  - Bit counter increments.
- HIGH → FINISH, on the last falling edge (bit counter = DATA_W-1):
  - SCLK=0, SS_n=1, MOSI=0, BUSY=0.
  - rx_reg=rx_shift, DONE=1 for exactly one cycle.
  - FINISH returns to IDLE on the next edge.
- Timing with accept at T:
  - First SCLK rise at T+1+CLK_DIV.
  - Final fall, together with BUSY low, SS_n high and DONE, at T+1+2·DATA_W·CLK_DIV.
  - Defaults: T+65.
- Stalled write (PSEL, PENABLE, PWRITE, PADDR held during BUSY):
  - PREADY goes high in the FINISH cycle.
  - The write is accepted on that edge and the new transfer starts with SS_n low at the next cycle.
  - SS_n stays high for at least one full PCLK cycle between transfers.
- Read of rx_reg on the same edge rx_reg updates: PRDATA reflects the old value in that cycle and the new value afterwards.
- MISO is treated as synchronous to PCLK; no synchroniser is included.
- CLK_DIV=1: SCLK = PCLK/2; the timing rules above still hold.

Test Plan:
1. Assert PRESET for 2 cycles with random inputs → SS_n=1, SCLK=0, BUSY=0, PREADY=1, PRDATA=0 after a read of PADDR=0.
2. Write 8'hA5 to PADDR=1, with MISO driven by a slave model returning 8'h3C (defaults) → 8 SCLK rises at T+5, T+13, …, T+61; MOSI bits 1,0,1,0,0,1,0,1 stable at each rise; DONE pulse at T+65; a subsequent read at PADDR=0 returns 8'h3C.
3. Issue a second TX write at T+10 during a transfer → PREADY=0 until the FINISH cycle; the second transfer starts with SS_n low 1 cycle after the first SS_n rise; the first rx_reg value is preserved until the second DONE.
4. Assert PRESET at T+30 mid-transfer → SS_n=1, SCLK=0 next cycle; no DONE; rx_reg=0; a new write then runs a clean full transfer.
5. Write with PADDR=0 (8'hFF), then read with PADDR=1 → no transfer starts (BUSY stays 0), PREADY=1, read returns 0.
6. CLK_DIV=1, write 8'h81 with MISO tied high → 16 SCLK half-periods of 1 PCLK each; DONE at T+17; rx_reg=8'hFF.
